// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 clock/data pair, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop), folds the E0/F0
// prefixes into ext/rel flags and queues {ext, rel, code} events in a small
// show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int TIMEOUT    = 16384,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ev_rd,
    input  logic       ovf_clr,
    output logic [9:0] ev_data,
    output logic       ev_empty,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic [2:0] clk_sync_reg;
    logic [1:0] data_sync_reg;
    logic       fe;
    logic       data_bit;

    // Two-flop synchronisers; the clock chain has a third stage for edge detect.
    // Reset to the idle-high level so release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    assign fe       = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign data_bit = data_sync_reg[1];

    // ------------------------------------------------------------------
    // Frame FSM, prefix flags and timeout
    // ------------------------------------------------------------------
    state_t          state_reg,     state_next;
    logic [2:0]      bit_idx_reg,   bit_idx_next;
    logic [7:0]      shift_reg,     shift_next;
    logic            par_acc_reg,   par_acc_next;
    logic            par_ok_reg,    par_ok_next;
    logic            ext_reg,       ext_next;
    logic            rel_reg,       rel_next;
    logic [CW-1:0]   to_cnt_reg,    to_cnt_next;
    logic            push_reg,      push_next;
    logic [9:0]      push_data_reg, push_data_next;
    logic            err_reg,       err_next;

    // Frame state register and its companions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            par_acc_reg   <= 1'b0;
            par_ok_reg    <= 1'b0;
            ext_reg       <= 1'b0;
            rel_reg       <= 1'b0;
            to_cnt_reg    <= '0;
            push_reg      <= 1'b0;
            push_data_reg <= 10'h000;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            par_acc_reg   <= par_acc_next;
            par_ok_reg    <= par_ok_next;
            ext_reg       <= ext_next;
            rel_reg       <= rel_next;
            to_cnt_reg    <= to_cnt_next;
            push_reg      <= push_next;
            push_data_reg <= push_data_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic: acts only on fe cycles, except for the timeout abort.
    always_comb begin
        state_next     = state_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        par_acc_next   = par_acc_reg;
        par_ok_next    = par_ok_reg;
        ext_next       = ext_reg;
        rel_next       = rel_reg;
        to_cnt_next    = to_cnt_reg;
        push_next      = 1'b0;
        push_data_next = push_data_reg;
        err_next       = 1'b0;

        // Counter restarts on every edge and saturates rather than wrapping.
        if (fe) begin
            to_cnt_next = '0;
        end else if (state_reg != IDLE && to_cnt_reg != TO_LAST) begin
            to_cnt_next = to_cnt_reg + CW'(1);
        end

        if (fe) begin
            case (state_reg)
                IDLE: begin
                    if (!data_bit) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                        par_acc_next = 1'b0;
                    end
                end
                DATA: begin
                    shift_next   = {data_bit, shift_reg[7:1]};
                    par_acc_next = par_acc_reg ^ data_bit;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_next = par_acc_reg ^ data_bit;
                    state_next  = STOP;
                end
                default: begin
                    state_next = IDLE;
                    if (data_bit && par_ok_reg) begin
                        if (shift_reg == 8'hE0) begin
                            ext_next = 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            rel_next = 1'b1;
                        end else begin
                            push_next      = 1'b1;
                            push_data_next = {ext_reg, rel_reg, shift_reg};
                            ext_next       = 1'b0;
                            rel_next       = 1'b0;
                        end
                    end else begin
                        err_next = 1'b1;
                        ext_next = 1'b0;
                        rel_next = 1'b0;
                    end
                end
            endcase
        end else if (state_reg != IDLE && to_cnt_reg == TO_LAST) begin
            // Stalled mid-frame: abandon it along with any pending prefix.
            state_next = IDLE;
            err_next   = 1'b1;
            ext_next   = 1'b0;
            rel_next   = 1'b0;
        end
    end

    assign frame_err = err_reg;

    // ------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        overflow_reg;
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;
    logic        drop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = ev_rd & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_reg & (~full | do_pop);
    assign drop    = push_reg & full & ~do_pop;

    // Storage: no reset needed, the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data_reg;
        end
    end

    // Pointers and the sticky overflow flag; a drop beats a concurrent clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign ev_empty = empty;
    assign ev_data  = empty ? 10'h000 : mem[rd_ptr_reg[AW-1:0]];
    assign overflow = overflow_reg;

endmodule
